// File: rtl/arb_mon_pkg.sv
// Shared types and helpers for the arbiter starvation monitor.
// Holds default widths, the capture FSM state type and the priority pick.
package arb_mon_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_NUM_LVLS = 4;
  localparam int PICK_MAX_W   = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } cap_state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int pick_lowest(
    input logic [PICK_MAX_W-1:0] v
  );
    pick_lowest = 0;
    for (int k = PICK_MAX_W - 1; k >= 0; k--) begin
      if (v[k]) pick_lowest = k;
    end
  endfunction

endpackage

// File: rtl/starv_wait_counter.sv
// One requestor's saturating wait counter and per-level bound compare.
// A level fires once per wait episode; the episode ends on grant or drop.
module starv_wait_counter
  import arb_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_LVLS = DEF_NUM_LVLS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      grant,
  input  logic [NUM_LVLS*CNT_W-1:0] thresh,
  output logic [CNT_W-1:0]          cnt,
  output logic [CNT_W-1:0]          cnt_nxt,
  output logic [NUM_LVLS-1:0]       set
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [NUM_LVLS-1:0] fired_q;
  logic [NUM_LVLS-1:0] fired_d;
  logic [NUM_LVLS-1:0] set_c;
  logic [CNT_W-1:0]    th;

  // Next count, level crossings and per-episode fired tracking.
  always_comb begin
    cnt_d = '0;
    set_c = '0;
    th    = '0;
    if (grant) begin
      cnt_d = '0;
    end else if (req) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    for (int j = 0; j < NUM_LVLS; j++) begin
      th = thresh[j*CNT_W +: CNT_W];
      if (req && !grant && th != '0 &&
          cnt_d >= th && !fired_q[j]) begin
        set_c[j] = 1'b1;
      end
    end
    if (grant || !req) begin
      fired_d = '0;
    end else begin
      fired_d = fired_q | set_c;
    end
  end

  // Counter and fired-level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fired_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;
  assign set     = set_c;

endmodule

// File: rtl/arb_starvation_monitor.sv
// Per-requestor starvation bounds, sticky flags, capture, irq, grant checks.
// Optional STARV_MON_PEAK_EN adds per-requestor peak wait tracking.
module arb_starvation_monitor
  import arb_mon_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_LVLS = DEF_NUM_LVLS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQS-1:0]           req,
  input  logic [NUM_REQS-1:0]           grant,
  input  logic [NUM_LVLS*CNT_W-1:0]     thresh,
  input  logic [NUM_LVLS-1:0]           irq_mask,
  input  logic                          clr,
  output logic [NUM_REQS*CNT_W-1:0]     wait_cnt,
  output logic [NUM_REQS*NUM_LVLS-1:0]  viol,
  output logic                          cap_valid,
  output logic [$clog2(NUM_REQS)-1:0]   cap_id,
  output logic [$clog2(NUM_LVLS)-1:0]   cap_lvl,
  output logic                          multi_gnt_err,
  output logic                          orphan_gnt_err,
  output logic                          irq
`ifdef STARV_MON_PEAK_EN
  ,
  output logic [NUM_REQS*CNT_W-1:0]     peak_wait
`endif
);

  localparam int NV   = NUM_REQS * NUM_LVLS;
  localparam int ID_W = $clog2(NUM_REQS);
  localparam int LV_W = $clog2(NUM_LVLS);

  logic [NUM_REQS*CNT_W-1:0] cnt_w;
  logic [NUM_REQS*CNT_W-1:0] nxt_w;
  logic [NV-1:0]             set_w;

  logic [NV-1:0]   viol_q;
  logic [NV-1:0]   viol_d;
  logic [NV-1:0]   base_v;
  logic [NV-1:0]   new_v;
  cap_state_e      state_q;
  cap_state_e      state_d;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_d;
  logic [LV_W-1:0] lvl_q;
  logic [LV_W-1:0] lvl_d;
  logic            multi_q;
  logic            multi_d;
  logic            orphan_q;
  logic            orphan_d;
  logic            irq_q;
  logic            irq_d;
  int              pick;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
    starv_wait_counter #(
      .CNT_W    (CNT_W),
      .NUM_LVLS (NUM_LVLS)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[i]),
      .grant   (grant[i]),
      .thresh  (thresh),
      .cnt     (cnt_w[i*CNT_W +: CNT_W]),
      .cnt_nxt (nxt_w[i*CNT_W +: CNT_W]),
      .set     (set_w[i*NUM_LVLS +: NUM_LVLS])
    );
  end

  // Sticky flags: clear applies first, then new sets land on top.
  always_comb begin
    base_v   = clr ? '0 : viol_q;
    new_v    = set_w & ~base_v;
    viol_d   = base_v | set_w;
    multi_d  = (clr ? 1'b0 : multi_q) |
               (|(grant & (grant - 1'b1)));
    orphan_d = (clr ? 1'b0 : orphan_q) |
               (|(grant & ~req));
    irq_d    = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      for (int j = 0; j < NUM_LVLS; j++) begin
        irq_d = irq_d |
                (viol_q[i*NUM_LVLS+j] & irq_mask[j]);
      end
    end
  end

  // Capture FSM: flat index order gives lowest requestor, then level.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    lvl_d   = lvl_q;
    pick    = pick_lowest(PICK_MAX_W'(new_v));
    unique case (state_q)
      IDLE: begin
        if (|new_v) begin
          state_d = HELD;
          id_d    = ID_W'(pick / NUM_LVLS);
          lvl_d   = LV_W'(pick % NUM_LVLS);
        end
      end
      HELD: begin
        if (clr) begin
          if (|new_v) begin
            id_d  = ID_W'(pick / NUM_LVLS);
            lvl_d = LV_W'(pick % NUM_LVLS);
          end else begin
            state_d = IDLE;
            id_d    = '0;
            lvl_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag, capture and irq registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_q   <= '0;
      state_q  <= IDLE;
      id_q     <= '0;
      lvl_q    <= '0;
      multi_q  <= 1'b0;
      orphan_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      viol_q   <= viol_d;
      state_q  <= state_d;
      id_q     <= id_d;
      lvl_q    <= lvl_d;
      multi_q  <= multi_d;
      orphan_q <= orphan_d;
      irq_q    <= irq_d;
    end
  end

  assign wait_cnt       = cnt_w;
  assign viol           = viol_q;
  assign cap_valid      = (state_q == HELD);
  assign cap_id         = id_q;
  assign cap_lvl        = lvl_q;
  assign multi_gnt_err  = multi_q;
  assign orphan_gnt_err = orphan_q;
  assign irq            = irq_q;

`ifdef STARV_MON_PEAK_EN
  logic [NUM_REQS*CNT_W-1:0] peak_q;
  logic [NUM_REQS*CNT_W-1:0] peak_d;

  // Peak follows the next count; a clear restarts it from that count.
  always_comb begin
    peak_d = peak_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (clr || nxt_w[i*CNT_W +: CNT_W] > peak_q[i*CNT_W +: CNT_W]) begin
        peak_d[i*CNT_W +: CNT_W] = nxt_w[i*CNT_W +: CNT_W];
      end
    end
  end

  // Peak registers.
  always_ff @(posedge clk) begin
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_wait = peak_q;
`else
  logic unused_nxt;
  assign unused_nxt = ^nxt_w;
`endif

endmodule

// File: tb/tb_arb_starvation_monitor.sv
// Scoreboard bench for arb_starvation_monitor.
// Expectations are queued per cycle and compared as cycles elapse.
module tb_arb_starvation_monitor;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int NL = 4;
  localparam int SW = 4;

  localparam int S_W0    = 0;
  localparam int S_W1    = 1;
  localparam int S_W2    = 2;
  localparam int S_W3    = 3;
  localparam int S_WALL  = 4;
  localparam int S_VIOL  = 5;
  localparam int S_CV    = 6;
  localparam int S_CID   = 7;
  localparam int S_CLV   = 8;
  localparam int S_MG    = 9;
  localparam int S_OG    = 10;
  localparam int S_IRQ   = 11;
  localparam int S_SW0   = 12;
  localparam int S_SVIOL = 13;
  localparam int S_SCV   = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             clr;
  logic [NR-1:0]    req;
  logic [NR-1:0]    grant;
  logic [NL*CW-1:0] thresh;
  logic [NL-1:0]    irq_mask;
  logic [NR*CW-1:0] wait_cnt;
  logic [NR*NL-1:0] viol;
  logic             cap_valid;
  logic [1:0]       cap_id;
  logic [1:0]       cap_lvl;
  logic             multi_gnt_err;
  logic             orphan_gnt_err;
  logic             irq;

  logic             clr_s;
  logic [NR-1:0]    req_s;
  logic [NR-1:0]    grant_s;
  logic [NL*SW-1:0] thresh_s;
  logic [NL-1:0]    irq_mask_s;
  logic [NR*SW-1:0] wait_cnt_s;
  logic [NR*NL-1:0] viol_s;
  logic             cap_valid_s;
  logic [1:0]       cap_id_s;
  logic [1:0]       cap_lvl_s;
  logic             multi_s;
  logic             orphan_s;
  logic             irq_s;
`ifdef STARV_MON_PEAK_EN
  logic [NR*CW-1:0] peak_wait;
  logic [NR*SW-1:0] peak_wait_s;
`endif

  arb_starvation_monitor #(
    .NUM_REQS (NR),
    .CNT_W    (CW),
    .NUM_LVLS (NL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .grant          (grant),
    .thresh         (thresh),
    .irq_mask       (irq_mask),
    .clr            (clr),
    .wait_cnt       (wait_cnt),
    .viol           (viol),
    .cap_valid      (cap_valid),
    .cap_id         (cap_id),
    .cap_lvl        (cap_lvl),
    .multi_gnt_err  (multi_gnt_err),
    .orphan_gnt_err (orphan_gnt_err),
    .irq            (irq)
`ifdef STARV_MON_PEAK_EN
    ,
    .peak_wait      (peak_wait)
`endif
  );

  arb_starvation_monitor #(
    .NUM_REQS (NR),
    .CNT_W    (SW),
    .NUM_LVLS (NL)
  ) dut_s (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req_s),
    .grant          (grant_s),
    .thresh         (thresh_s),
    .irq_mask       (irq_mask_s),
    .clr            (clr_s),
    .wait_cnt       (wait_cnt_s),
    .viol           (viol_s),
    .cap_valid      (cap_valid_s),
    .cap_id         (cap_id_s),
    .cap_lvl        (cap_lvl_s),
    .multi_gnt_err  (multi_s),
    .orphan_gnt_err (orphan_s),
    .irq            (irq_s)
`ifdef STARV_MON_PEAK_EN
    ,
    .peak_wait      (peak_wait_s)
`endif
  );

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_W0:    obs = 32'(wait_cnt[7:0]);
      S_W1:    obs = 32'(wait_cnt[15:8]);
      S_W2:    obs = 32'(wait_cnt[23:16]);
      S_W3:    obs = 32'(wait_cnt[31:24]);
      S_WALL:  obs = wait_cnt;
      S_VIOL:  obs = 32'(viol);
      S_CV:    obs = 32'(cap_valid);
      S_CID:   obs = 32'(cap_id);
      S_CLV:   obs = 32'(cap_lvl);
      S_MG:    obs = 32'(multi_gnt_err);
      S_OG:    obs = 32'(orphan_gnt_err);
      S_IRQ:   obs = 32'(irq);
      S_SW0:   obs = 32'(wait_cnt_s[3:0]);
      S_SVIOL: obs = 32'(viol_s);
      S_SCV:   obs = 32'(cap_valid_s);
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input int c, input int s,
                           input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.nm  = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    req   = '0;
    grant = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    req   = 4'b1111;
    grant = 4'b0110;
    clr   = 1'b0;
    expect_at(2, S_WALL, 0, "rst_wait");
    expect_at(2, S_VIOL, 0, "rst_viol");
    expect_at(2, S_CV, 0, "rst_cap_valid");
    expect_at(2, S_MG, 0, "rst_multi");
    expect_at(2, S_OG, 0, "rst_orphan");
    expect_at(2, S_IRQ, 0, "rst_irq");
    expect_at(2, S_SW0, 0, "rst_small_wait");
    for (int n = 1; n <= 2; n++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    req   = '0;
    grant = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_levels();
    exp_t e;
    do_reset();
    thresh   = 32'h644B_3219;
    irq_mask = 4'b1111;
    req      = 4'b0100;
    expect_at(24, S_W2, 24, "lv_w24");
    expect_at(24, S_VIOL, 0, "lv_viol24");
    expect_at(24, S_CV, 0, "lv_cv24");
    expect_at(25, S_W2, 25, "lv_w25");
    expect_at(25, S_VIOL, 32'h0100, "lv_viol25");
    expect_at(25, S_CV, 1, "lv_cv25");
    expect_at(25, S_CID, 2, "lv_cid25");
    expect_at(25, S_CLV, 0, "lv_clv25");
    expect_at(25, S_IRQ, 0, "lv_irq25");
    expect_at(26, S_IRQ, 1, "lv_irq26");
    expect_at(49, S_VIOL, 32'h0100, "lv_viol49");
    expect_at(50, S_VIOL, 32'h0300, "lv_viol50");
    expect_at(50, S_CLV, 0, "lv_clv50");
    expect_at(75, S_VIOL, 32'h0700, "lv_viol75");
    expect_at(100, S_VIOL, 32'h0F00, "lv_viol100");
    expect_at(100, S_W2, 100, "lv_w100");
    for (int n = 1; n <= 100; n++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_grant_rescue();
    exp_t e;
    do_reset();
    thresh   = 32'h644B_3219;
    irq_mask = 4'b1111;
    req      = 4'b0010;
    expect_at(24, S_W1, 24, "gr_w24");
    expect_at(25, S_W1, 0, "gr_w25");
    expect_at(25, S_VIOL, 0, "gr_viol25");
    expect_at(25, S_CV, 0, "gr_cv25");
    expect_at(25, S_OG, 0, "gr_orphan");
    expect_at(25, S_MG, 0, "gr_multi");
    expect_at(30, S_W1, 5, "gr_w30");
    expect_at(30, S_VIOL, 0, "gr_viol30");
    for (int n = 1; n <= 30; n++) begin
      grant = (n == 25) ? 4'b0010 : 4'b0000;
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    grant = '0;
    req   = '0;
  endtask

  task automatic test_tie_and_clr();
    exp_t e;
    do_reset();
    thresh   = 32'h644B_3219;
    irq_mask = 4'b0001;
    req      = 4'b1001;
    expect_at(24, S_VIOL, 0, "tc_viol24");
    expect_at(25, S_VIOL, 32'h1001, "tc_viol25");
    expect_at(25, S_CV, 1, "tc_cv25");
    expect_at(25, S_CID, 0, "tc_cid25");
    expect_at(25, S_CLV, 0, "tc_clv25");
    expect_at(26, S_IRQ, 1, "tc_irq26");
    expect_at(30, S_VIOL, 0, "tc_viol_clr");
    expect_at(30, S_CV, 0, "tc_cv_clr");
    expect_at(30, S_W0, 30, "tc_w0_clr");
    expect_at(30, S_W3, 30, "tc_w3_clr");
    expect_at(30, S_IRQ, 1, "tc_irq30");
    expect_at(31, S_IRQ, 0, "tc_irq31");
    expect_at(49, S_VIOL, 0, "tc_viol49");
    expect_at(50, S_VIOL, 32'h2002, "tc_viol50");
    expect_at(50, S_CV, 1, "tc_cv50");
    expect_at(50, S_CID, 0, "tc_cid50");
    expect_at(50, S_CLV, 1, "tc_clv50");
    expect_at(51, S_IRQ, 0, "tc_irq_masked");
    for (int n = 1; n <= 51; n++) begin
      clr = (n == 30);
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    clr = 1'b0;
    req = '0;
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    thresh_s = 16'h000F;
    req_s    = 4'b0001;
    expect_at(14, S_SW0, 14, "sat_w14");
    expect_at(14, S_SVIOL, 0, "sat_viol14");
    expect_at(15, S_SW0, 15, "sat_w15");
    expect_at(15, S_SVIOL, 1, "sat_viol15");
    expect_at(15, S_SCV, 1, "sat_cv15");
    expect_at(16, S_SW0, 15, "sat_w16");
    expect_at(19, S_SVIOL, 1, "sat_viol19");
    expect_at(20, S_SVIOL, 3, "sat_newth20");
    expect_at(40, S_SW0, 15, "sat_w40");
    expect_at(40, S_SVIOL, 3, "sat_viol40");
    for (int n = 1; n <= 40; n++) begin
      if (n == 20) thresh_s = 16'h00AF;
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    req_s = '0;
  endtask

  task automatic test_protocol();
    exp_t e;
    do_reset();
    thresh   = 32'h644B_3219;
    irq_mask = 4'b1111;
    expect_at(1, S_MG, 1, "pr_multi1");
    expect_at(1, S_OG, 0, "pr_orphan1");
    expect_at(2, S_MG, 1, "pr_multi2");
    expect_at(2, S_OG, 1, "pr_orphan2");
    expect_at(3, S_MG, 0, "pr_multi_clr");
    expect_at(3, S_OG, 0, "pr_orphan_clr");
    expect_at(4, S_MG, 0, "pr_multi_ok");
    expect_at(4, S_OG, 0, "pr_orphan_ok");
    for (int n = 1; n <= 4; n++) begin
      case (n)
        1: begin req = 4'b0101; grant = 4'b0101; clr = 1'b0; end
        2: begin req = 4'b0000; grant = 4'b0010; clr = 1'b0; end
        3: begin req = 4'b0000; grant = 4'b0000; clr = 1'b1; end
        default: begin req = 4'b0010; grant = 4'b0010; clr = 1'b0; end
      endcase
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    req   = '0;
    grant = '0;
    clr   = 1'b0;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    thresh   = 32'h644B_3219;
    irq_mask = 4'b1111;
    req      = 4'b0001;
    expect_at(30, S_W0, 30, "mr_w30");
    expect_at(30, S_IRQ, 1, "mr_irq30");
    expect_at(30, S_VIOL, 1, "mr_viol30");
    expect_at(31, S_WALL, 0, "mr_wall31");
    expect_at(31, S_VIOL, 0, "mr_viol31");
    expect_at(31, S_CV, 0, "mr_cv31");
    expect_at(31, S_IRQ, 0, "mr_irq31");
    expect_at(32, S_W0, 1, "mr_w32");
    expect_at(33, S_W0, 2, "mr_w33");
    expect_at(55, S_VIOL, 0, "mr_viol55");
    expect_at(56, S_VIOL, 1, "mr_viol56");
    expect_at(56, S_W0, 25, "mr_w56");
    for (int n = 1; n <= 56; n++) begin
      rst_n = (n != 31);
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    rst_n = 1'b1;
    req   = '0;
  endtask

  task automatic test_clr_collision();
    exp_t e;
    do_reset();
    thresh   = 32'h0000_190A;
    irq_mask = 4'b1111;
    req      = 4'b0100;
    expect_at(10, S_VIOL, 32'h0100, "cc_viol10");
    expect_at(10, S_CV, 1, "cc_cv10");
    expect_at(10, S_CLV, 0, "cc_clv10");
    expect_at(11, S_IRQ, 1, "cc_irq11");
    expect_at(25, S_VIOL, 32'h0200, "cc_viol25");
    expect_at(25, S_CV, 1, "cc_cv25");
    expect_at(25, S_CID, 2, "cc_cid25");
    expect_at(25, S_CLV, 1, "cc_clv25");
    expect_at(26, S_IRQ, 1, "cc_irq26");
    for (int n = 1; n <= 26; n++) begin
      clr = (n == 25);
      step();
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sig) !== e.val) begin
          bad++;
          $display("FAIL %s got %0h want %0h", e.nm, obs(e.sig), e.val);
        end
      end
    end
    clr = 1'b0;
    req = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    req        = '0;
    grant      = '0;
    thresh     = '0;
    irq_mask   = '0;
    clr_s      = 1'b0;
    req_s      = '0;
    grant_s    = '0;
    thresh_s   = '0;
    irq_mask_s = '0;
    test_reset();
    test_levels();
    test_grant_rescue();
    test_tie_and_clr();
    test_saturation();
    test_protocol();
    test_mid_reset();
    test_clr_collision();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
